// File: rtl/data_memory_arbiter_pkg.sv
// Shared types for the data memory arbiter, kept next to the stage-2 opcode constants
// so the cpu_req decode can reuse the same opcode set.
package data_memory_arbiter_pkg;

   // Stage-2 opcodes that touch data memory.
   localparam logic [5:0] OP_LOAD_FROM_MEMORY = 6'h10;
   localparam logic [5:0] OP_STORE_TO_MEMORY  = 6'h11;
   localparam logic [5:0] OP_CALL             = 6'h20;
   localparam logic [5:0] OP_RETURN           = 6'h21;

   typedef enum logic {
      ARB_RUN,
      ARB_LOCKED
   } arb_state_e;

   typedef enum logic [1:0] {
      GRANT_NONE,
      GRANT_CPU,
      GRANT_EXT
   } grant_e;

   // True for opcodes that must raise cpu_req; bubbles and ALU ops never do.
   function automatic logic op_uses_memory(input logic [5:0] opcode);
      return (opcode == OP_LOAD_FROM_MEMORY) || (opcode == OP_STORE_TO_MEMORY) ||
             (opcode == OP_CALL) || (opcode == OP_RETURN);
   endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the two requesters (CPU stage 2, EXT port), the arbiter and the data RAM.
// master = requesters plus RAM side, slave = the arbiter.
interface data_memory_arbiter_if #(
   parameter int ADDR_SIZE = 18,
   parameter int WORD_SIZE = 18
);
   logic                 cpu_req;
   logic [ADDR_SIZE-1:0] cpu_addr;
   logic                 cpu_we;
   logic [WORD_SIZE-1:0] cpu_wdata;
   logic                 cpu_stall;
   logic [WORD_SIZE-1:0] cpu_rdata;

   logic                 ext_valid;
   logic [ADDR_SIZE-1:0] ext_addr;
   logic                 ext_we;
   logic [WORD_SIZE-1:0] ext_wdata;
   logic                 ext_ready;
   logic                 ext_rvalid;
   logic [WORD_SIZE-1:0] ext_rdata;
   logic                 ext_lock_req;
   logic                 ext_lock_ack;

   logic [ADDR_SIZE-1:0] mem_addr;
   logic                 mem_we;
   logic [WORD_SIZE-1:0] mem_wdata;
   logic [WORD_SIZE-1:0] mem_rdata;

   modport master (
      output cpu_req, cpu_addr, cpu_we, cpu_wdata,
      input  cpu_stall, cpu_rdata,
      output ext_valid, ext_addr, ext_we, ext_wdata, ext_lock_req,
      input  ext_ready, ext_rvalid, ext_rdata, ext_lock_ack,
      input  mem_addr, mem_we, mem_wdata,
      output mem_rdata
   );

   modport slave (
      input  cpu_req, cpu_addr, cpu_we, cpu_wdata,
      output cpu_stall, cpu_rdata,
      input  ext_valid, ext_addr, ext_we, ext_wdata, ext_lock_req,
      output ext_ready, ext_rvalid, ext_rdata, ext_lock_ack,
      output mem_addr, mem_we, mem_wdata,
      input  mem_rdata
   );

endinterface

// File: rtl/arbiter_starve_counter.sv
// Counts consecutive contended cycles the CPU has won; saturates at MAX_COUNT.
// Clear has priority over increment.
module arbiter_starve_counter #(
   parameter int MAX_COUNT = 4,
   parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             incr,
   output logic [CNT_W-1:0] count
);

   // NOTE: state registers use non-blocking assignments and an async reset so every
   // flop in the block samples the same pre-edge values and resets without a clock.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (incr && (count != CNT_W'(MAX_COUNT))) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/data_memory_arbiter.sv
// Data memory arbiter: shares the single-port data RAM between the CPU stage-2 port (priority)
// and an EXT port with starvation relief and an exclusive lock. Option: DATA_MEMORY_ARBITER_STATS_EN.
module data_memory_arbiter
   import data_memory_arbiter_pkg::*;
#(
   parameter int ADDR_SIZE     = 18,
   parameter int WORD_SIZE     = 18,
   parameter int MAX_CPU_BURST = 4
) (
   input  logic                 clock,
   input  logic                 reset_n,
   data_memory_arbiter_if.slave bus
`ifdef DATA_MEMORY_ARBITER_STATS_EN
   ,
   output logic [15:0]          stat_cpu_stalls,
   output logic [15:0]          stat_ext_grants
`endif
);

   localparam int CNT_W = $clog2(MAX_CPU_BURST + 1);

   arb_state_e           state_q;
   arb_state_e           state_d;
   grant_e               grant;
   logic [CNT_W-1:0]     starve_cnt;
   logic                 starve_clear;
   logic                 starve_incr;
   logic                 starve_at_max;
   logic                 ext_rvalid_q;
   logic                 cpu_stall;
   logic                 ext_ready;
   logic [ADDR_SIZE-1:0] win_addr;
   logic [WORD_SIZE-1:0] win_wdata;
   logic                 win_we;

   arbiter_starve_counter #(
      .MAX_COUNT (MAX_CPU_BURST),
      .CNT_W     (CNT_W)
   ) u_starve (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (starve_clear),
      .incr    (starve_incr),
      .count   (starve_cnt)
   );

   assign starve_at_max = (starve_cnt == CNT_W'(MAX_CPU_BURST));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ARB_RUN;
         ext_rvalid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ext_rvalid_q <= (grant == GRANT_EXT) && !bus.ext_we;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path leaves one unassigned
   // and no latch is inferred.
   always_comb begin
      grant        = GRANT_NONE;
      starve_clear = 1'b0;
      starve_incr  = 1'b0;
      state_d      = bus.ext_lock_req ? ARB_LOCKED : ARB_RUN;
      case (state_q)
         ARB_RUN: begin
            if (bus.cpu_req && bus.ext_valid) begin
               if (starve_at_max) begin
                  grant        = GRANT_EXT;
                  starve_clear = 1'b1;
               end else begin
                  grant        = GRANT_CPU;
                  starve_incr  = 1'b1;
               end
            end else if (bus.cpu_req) begin
               grant = GRANT_CPU;
            end else if (bus.ext_valid) begin
               grant        = GRANT_EXT;
               starve_clear = 1'b1;
            end
         end
         ARB_LOCKED: begin
            starve_clear = 1'b1;
            if (bus.ext_valid) grant = GRANT_EXT;
         end
         default: grant = GRANT_NONE;
      endcase
      // The count is zero from the edge the lock is taken, so LOCKED never sees a stale burst.
      if (bus.ext_lock_req) starve_clear = 1'b1;
   end

   // Winner drives the RAM; with no winner the CPU address leaks through harmlessly.
   always_comb begin
      win_addr  = bus.cpu_addr;
      win_wdata = bus.cpu_wdata;
      win_we    = 1'b0;
      case (grant)
         GRANT_CPU: win_we = bus.cpu_we;
         GRANT_EXT: begin
            win_addr  = bus.ext_addr;
            win_wdata = bus.ext_wdata;
            win_we    = bus.ext_we;
         end
         default: win_we = 1'b0;
      endcase
   end

   // Handshake outputs are held inactive while reset is asserted, independent of the clock.
   assign cpu_stall = reset_n && bus.cpu_req && (grant != GRANT_CPU);
   assign ext_ready = reset_n && (grant == GRANT_EXT);

   assign bus.mem_addr     = win_addr;
   assign bus.mem_wdata    = win_wdata;
   assign bus.mem_we       = reset_n && win_we;
   assign bus.cpu_stall    = cpu_stall;
   assign bus.ext_ready    = ext_ready;
   assign bus.cpu_rdata    = bus.mem_rdata;
   assign bus.ext_rdata    = bus.mem_rdata;
   assign bus.ext_rvalid   = ext_rvalid_q;
   assign bus.ext_lock_ack = (state_q == ARB_LOCKED);

`ifdef DATA_MEMORY_ARBITER_STATS_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stat_cpu_stalls <= '0;
         stat_ext_grants <= '0;
      end else begin
         if (cpu_stall && (stat_cpu_stalls != 16'hFFFF)) stat_cpu_stalls <= stat_cpu_stalls + 16'd1;
         if (ext_ready && (stat_ext_grants != 16'hFFFF)) stat_ext_grants <= stat_ext_grants + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the arbitration rules and a shadow RAM.
module tb_data_memory_arbiter;

   localparam int ADDR_SIZE     = 18;
   localparam int WORD_SIZE     = 18;
   localparam int MAX_CPU_BURST = 4;
   localparam int NONE = 0, CPU = 1, EXT = 2;

   logic clock = 1'b0;
   logic reset_n = 1'b0;

   data_memory_arbiter_if #(.ADDR_SIZE(ADDR_SIZE), .WORD_SIZE(WORD_SIZE)) bus ();

`ifdef DATA_MEMORY_ARBITER_STATS_EN
   logic [15:0] stat_cpu_stalls;
   logic [15:0] stat_ext_grants;
`endif

   data_memory_arbiter #(
      .ADDR_SIZE     (ADDR_SIZE),
      .WORD_SIZE     (WORD_SIZE),
      .MAX_CPU_BURST (MAX_CPU_BURST)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
`ifdef DATA_MEMORY_ARBITER_STATS_EN
      ,
      .stat_cpu_stalls (stat_cpu_stalls),
      .stat_ext_grants (stat_ext_grants)
`endif
   );

   always #5 clock = ~clock;

   // Synchronous single-port RAM, read-first, one-cycle read latency.
   logic [WORD_SIZE-1:0] ram [0:1023] = '{default: '0};
   always @(posedge clock) begin
      if (bus.mem_we) ram[bus.mem_addr[9:0]] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr[9:0]];
   end

   // Reference model state
   logic [WORD_SIZE-1:0] ref_mem [0:1023];
   bit                   m_locked;
   int                   m_starve;
   bit                   m_ext_rd_pend;
   logic [WORD_SIZE-1:0] m_ext_rd_data;
   bit                   m_cpu_rd_pend;
   logic [WORD_SIZE-1:0] m_cpu_rd_data;
   int                   m_stalls;
   int                   m_grants;

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, actual, expected);
      end
   endtask

   task automatic model_reset();
      m_locked      = 1'b0;
      m_starve      = 0;
      m_ext_rd_pend = 1'b0;
      m_cpu_rd_pend = 1'b0;
      m_stalls      = 0;
      m_grants      = 0;
   endtask

   task automatic drive_idle();
      bus.cpu_req      = 1'b0;
      bus.cpu_addr     = '0;
      bus.cpu_we       = 1'b0;
      bus.cpu_wdata    = '0;
      bus.ext_valid    = 1'b0;
      bus.ext_addr     = '0;
      bus.ext_we       = 1'b0;
      bus.ext_wdata    = '0;
      bus.ext_lock_req = 1'b0;
   endtask

   // One clock cycle: drive, check against the model at the falling edge, advance the model.
   task automatic step(input bit c_req, input logic [17:0] c_addr, input bit c_we,
                       input logic [17:0] c_wd, input bit e_val, input logic [17:0] e_addr,
                       input bit e_we, input logic [17:0] e_wd, input bit lock,
                       output bit stall_seen, output bit ready_seen);
      int win;
      bus.cpu_req      = c_req;
      bus.cpu_addr     = c_addr;
      bus.cpu_we       = c_we;
      bus.cpu_wdata    = c_wd;
      bus.ext_valid    = e_val;
      bus.ext_addr     = e_addr;
      bus.ext_we       = e_we;
      bus.ext_wdata    = e_wd;
      bus.ext_lock_req = lock;
      @(negedge clock);
      if (m_locked)             win = e_val ? EXT : NONE;
      else if (c_req && e_val)  win = (m_starve >= MAX_CPU_BURST) ? EXT : CPU;
      else if (c_req)           win = CPU;
      else if (e_val)           win = EXT;
      else                      win = NONE;
      stall_seen = bus.cpu_stall;
      ready_seen = bus.ext_ready;
      check("cpu_stall", bus.cpu_stall, c_req && (win != CPU));
      check("ext_ready", bus.ext_ready, win == EXT);
      check("mem_we", bus.mem_we, (win == CPU && c_we) || (win == EXT && e_we));
      check("mem_addr", bus.mem_addr, (win == EXT) ? e_addr : c_addr);
      if (win == CPU && c_we) check("mem_wdata_cpu", bus.mem_wdata, c_wd);
      if (win == EXT && e_we) check("mem_wdata_ext", bus.mem_wdata, e_wd);
      check("ext_lock_ack", bus.ext_lock_ack, m_locked);
      check("ext_rvalid", bus.ext_rvalid, m_ext_rd_pend);
      if (m_ext_rd_pend) check("ext_rdata", bus.ext_rdata, m_ext_rd_data);
      if (m_cpu_rd_pend) check("cpu_rdata", bus.cpu_rdata, m_cpu_rd_data);
`ifdef DATA_MEMORY_ARBITER_STATS_EN
      check("stat_cpu_stalls", stat_cpu_stalls, m_stalls);
      check("stat_ext_grants", stat_ext_grants, m_grants);
`endif
      m_ext_rd_pend = (win == EXT) && !e_we;
      if (m_ext_rd_pend) m_ext_rd_data = ref_mem[e_addr[9:0]];
      m_cpu_rd_pend = (win == CPU) && !c_we;
      if (m_cpu_rd_pend) m_cpu_rd_data = ref_mem[c_addr[9:0]];
      if (win == CPU && c_we) ref_mem[c_addr[9:0]] = c_wd;
      if (win == EXT && e_we) ref_mem[e_addr[9:0]] = e_wd;
      if (c_req && win != CPU && m_stalls < 65535) m_stalls++;
      if (win == EXT && m_grants < 65535) m_grants++;
      if (m_locked || lock || win == EXT) m_starve = 0;
      else if (win == CPU && e_val)       m_starve++;
      m_locked = lock;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      drive_idle();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      @(posedge clock);
      #1;
   endtask

   task automatic random_phase(input int cycles);
      bit lock = 1'b0;
      bit s, r;
      for (int i = 0; i < cycles; i++) begin
         if ($urandom_range(0, 24) == 0) lock = !lock;
         step($urandom_range(0, 9) < 7, 18'($urandom_range(0, 31)), $urandom_range(0, 2) == 0,
              18'($urandom), $urandom_range(0, 1) == 1, 18'($urandom_range(0, 31)),
              $urandom_range(0, 1) == 1, 18'($urandom), lock, s, r);
      end
   endtask

   initial begin
      bit s, r;
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      drive_idle();
      model_reset();

      // Reset and idle
      #12;
      check("rst_mem_we", bus.mem_we, 1'b0);
      check("rst_ext_ready", bus.ext_ready, 1'b0);
      check("rst_cpu_stall", bus.cpu_stall, 1'b0);
      check("rst_lock_ack", bus.ext_lock_ack, 1'b0);
      check("rst_ext_rvalid", bus.ext_rvalid, 1'b0);
      do_reset();
      repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0, s, r);

      // Sustained contention: EXT forced through every MAX_CPU_BURST+1 cycles
      for (int i = 0; i < 10; i++) begin
         step(1, 18'(i), 0, 0, 1, 18'h40 + 18'(i), 0, 0, 0, s, r);
         check("burst_stall", s, (i % 5) == 4);
         check("burst_ext_ready", r, (i % 5) == 4);
      end
`ifdef DATA_MEMORY_ARBITER_STATS_EN
      check("stat_ext_grants_10", stat_ext_grants, 16'd2);
      check("stat_cpu_stalls_10", stat_cpu_stalls, 16'd2);
`endif

      // EXT write then read back
      step(0, 0, 0, 0, 1, 18'h100, 1, 18'h2AAAA, 0, s, r);
      check("ext_wr_ready", r, 1'b1);
      step(0, 0, 0, 0, 1, 18'h100, 0, 0, 0, s, r);
      check("ext_rd_ready", r, 1'b1);
      check("ext_rd_rvalid", bus.ext_rvalid, 1'b1);
      check("ext_rd_data", bus.ext_rdata, 18'h2AAAA);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, s, r);

      // Lock while the CPU is busy; held CPU store lands only after release
      step(1, 18'h20, 0, 0, 0, 0, 0, 0, 1, s, r);
      check("lock_req_cycle_stall", s, 1'b0);
      check("lock_ack_after_edge", bus.ext_lock_ack, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(1, 18'h10, 1, 18'd7, i == 1, 18'h10, 0, 0, 1, s, r);
         check("locked_stall", s, 1'b1);
      end
      step(1, 18'h10, 1, 18'd7, 0, 0, 0, 0, 0, s, r);
      check("unlock_cycle_stall", s, 1'b1);
      check("unlock_ack_dropped", bus.ext_lock_ack, 1'b0);
      step(1, 18'h10, 1, 18'd7, 0, 0, 0, 0, 0, s, r);
      check("run_store_granted", s, 1'b0);
      step(0, 0, 0, 0, 1, 18'h10, 0, 0, 0, s, r);
      check("store_visible", bus.ext_rdata, 18'd7);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, s, r);

      random_phase(800);

      // Asynchronous reset in the middle of a lock with an EXT read in flight
      step(1, 18'h3, 0, 0, 0, 0, 0, 0, 1, s, r);
      step(1, 18'h3, 0, 0, 1, 18'h100, 0, 0, 1, s, r);
      check("pre_rst_ack", bus.ext_lock_ack, 1'b1);
      check("pre_rst_rvalid", bus.ext_rvalid, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_ack", bus.ext_lock_ack, 1'b0);
      check("async_rst_rvalid", bus.ext_rvalid, 1'b0);
      check("async_rst_mem_we", bus.mem_we, 1'b0);
      check("async_rst_ext_ready", bus.ext_ready, 1'b0);
      check("async_rst_cpu_stall", bus.cpu_stall, 1'b0);
      do_reset();
      step(1, 18'h5, 0, 0, 0, 0, 0, 0, 1, s, r);
      check("post_rst_run", s, 1'b0);
      step(1, 18'h5, 0, 0, 0, 0, 0, 0, 0, s, r);
      check("post_rst_relock_stall", s, 1'b1);

      random_phase(300);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
